// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register.
// State encoding doubles as the occupancy count.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional skid entry,
// flush-to-bubble and a saturating back-pressure counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned BUS_DATA = 32,
  parameter int          SKID     = 1,
  parameter logic [BUS_DATA-1:0] BUBBLE_VALUE =
    BUS_DATA'(NOP_BUBBLE),
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [BUS_DATA-1:0] i_data,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [BUS_DATA-1:0] o_data,
  output logic [1:0]          o_occupancy,
  output logic [CNT_W-1:0]    o_stall_cnt
);

  state_t              state, state_n;
  logic [BUS_DATA-1:0] main_q, main_n;
  logic [BUS_DATA-1:0] skid_q, skid_n;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_fire, out_fire;

  assign o_valid     = (state != ST_EMPTY);
  assign o_data      = main_q;
  assign o_occupancy = state;
  assign o_stall_cnt = cnt_q;
  assign in_fire     = i_valid & o_ready;
  assign out_fire    = o_valid & i_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_q <= 1'b1;
        else      ready_q <= (state_n != ST_TWO);
      end
      assign o_ready = ready_q;
    end else begin : g_noskid
      // Combinational path: a draining consumer frees the slot now
      assign o_ready = ~o_valid | i_ready;
    end
  endgenerate

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (i_flush) begin
      state_n = ST_EMPTY;
      main_n  = BUBBLE_VALUE;
      skid_n  = BUBBLE_VALUE;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_n = ST_ONE;
            main_n  = i_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_n = i_data;
          end else if (in_fire) begin
            state_n = ST_TWO;
            skid_n  = i_data;
          end else if (out_fire) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_n = ST_ONE;
            main_n  = skid_q;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_EMPTY;
      main_q <= BUBBLE_VALUE;
      skid_q <= BUBBLE_VALUE;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (o_valid && !i_ready && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
